fft_stage_sequencer: RTL and testbench

Parametrised stage sequencer for the radix-2 DIT FFT datapath. It steps the butterfly array through `N_STAGES` stages per frame and drives the stage-select (`sb`) and input-select (`isl`) controls. It also emits a frame-done pulse and a `VALID_LEN`-cycle output-valid window. Beyond the fixed 5-stage controller it adds a start/ready handshake, back-to-back frames with no idle bubble, a stage-stall input and a synchronous abort.

---
 rtl/fft_stage_sequencer.sv | 125 ++++++++++++
 tb/tb_fft_stage_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fft_stage_sequencer.sv
// Stage sequencer for the radix-2 DIT FFT butterfly array: walks sb through
// 1..N_STAGES per frame, and raises frame_done plus a VALID_LEN-cycle valid window.
module fft_stage_sequencer #(
    parameter  int N_STAGES  = 5,
    parameter  int VALID_LEN = 5,
    localparam int SB_W      = $clog2(N_STAGES + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            stall,
    input  logic            abort,
    output logic            ready,
    output logic            busy,
    output logic [SB_W-1:0] sb,
    output logic            isl,
    output logic            stage_first,
    output logic            stage_last,
    output logic            frame_done,
    output logic            valid,
    output logic            fsm_state
);

    localparam int CNT_W = $clog2(VALID_LEN + 1);

    localparam logic [SB_W-1:0]  SB_ONE   = SB_W'(1);
    localparam logic [SB_W-1:0]  SB_LAST  = SB_W'(N_STAGES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(VALID_LEN);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [SB_W-1:0]  sb_next;
    logic             run_next;
    logic             frame_done_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             valid_next;

    // Handshake: a frame is accepted on any edge where start && ready is high.
    // ready is high in IDLE, or in an unstalled last stage (back-to-back
    // frames), and is always forced low while abort is asserted.
    assign ready       = !abort && ((state == IDLE) || ((sb == SB_LAST) && !stall));
    assign stage_first = busy && (sb == SB_ONE);
    assign stage_last  = busy && (sb == SB_LAST);
    assign fsm_state   = state;

    always_comb begin
        state_next      = state;
        sb_next         = sb;
        run_next        = busy;
        frame_done_next = 1'b0;
        cnt_next        = (cnt != '0) ? cnt - CNT_ONE : '0;
        valid_next      = (cnt > CNT_ONE);

        unique case (state)
            IDLE: begin
                if (start && ready) begin
                    state_next = RUN;
                    sb_next    = SB_ONE;
                    run_next   = 1'b1;
                end
            end
            RUN: begin
                if (!stall) begin
                    if (sb != SB_LAST) begin
                        sb_next = sb + SB_ONE;
                    end else begin
                        // Frame complete: (re)open the valid window.
                        frame_done_next = 1'b1;
                        cnt_next        = CNT_LOAD;
                        valid_next      = 1'b1;
                        if (start) begin
                            sb_next = SB_ONE;
                        end else begin
                            state_next = IDLE;
                            sb_next    = '0;
                            run_next   = 1'b0;
                        end
                    end
                end
            end
            default: begin
                state_next = IDLE;
                sb_next    = '0;
                run_next   = 1'b0;
            end
        endcase

        if (abort) begin
            state_next      = IDLE;
            sb_next         = '0;
            run_next        = 1'b0;
            frame_done_next = 1'b0;
            cnt_next        = '0;
            valid_next      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sb         <= '0;
            busy       <= 1'b0;
            isl        <= 1'b0;
            frame_done <= 1'b0;
            cnt        <= '0;
            valid      <= 1'b0;
        end else begin
            state      <= state_next;
            sb         <= sb_next;
            busy       <= run_next;
            isl        <= run_next;
            frame_done <= frame_done_next;
            cnt        <= cnt_next;
            valid      <= valid_next;
        end
    end

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Bench for fft_stage_sequencer: four parameterisations share stimulus and are
// compared every cycle against a deadline-based reference model.
module tb_fft_stage_sequencer;

    localparam int NI = 4;
    localparam int NS [NI] = '{5, 1, 3, 10};
    localparam int VL [NI] = '{5, 1, 8, 8};

    logic clk;
    logic rst_n;
    logic start;
    logic stall;
    logic abort;

    logic       ready0, busy0, isl0, first0, last0, fd0, valid0, st0;
    logic [2:0] sb0;
    logic       ready1, busy1, isl1, first1, last1, fd1, valid1, st1;
    logic [0:0] sb1;
    logic       ready2, busy2, isl2, first2, last2, fd2, valid2, st2;
    logic [1:0] sb2;
    logic       ready3, busy3, isl3, first3, last3, fd3, valid3, st3;
    logic [3:0] sb3;

    logic [11:0] obs [NI];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: per instance, whether a frame is running, which stage
    // it is in, a frame_done flag, and the last cycle the valid window covers.
    bit m_busy  [NI];
    int m_stage [NI];
    bit m_fd    [NI];
    int m_vend  [NI];

    fft_stage_sequencer #(.N_STAGES(5), .VALID_LEN(5)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .abort(abort),
        .ready(ready0), .busy(busy0), .sb(sb0), .isl(isl0), .stage_first(first0),
        .stage_last(last0), .frame_done(fd0), .valid(valid0), .fsm_state(st0));

    fft_stage_sequencer #(.N_STAGES(1), .VALID_LEN(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .abort(abort),
        .ready(ready1), .busy(busy1), .sb(sb1), .isl(isl1), .stage_first(first1),
        .stage_last(last1), .frame_done(fd1), .valid(valid1), .fsm_state(st1));

    fft_stage_sequencer #(.N_STAGES(3), .VALID_LEN(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .abort(abort),
        .ready(ready2), .busy(busy2), .sb(sb2), .isl(isl2), .stage_first(first2),
        .stage_last(last2), .frame_done(fd2), .valid(valid2), .fsm_state(st2));

    fft_stage_sequencer #(.N_STAGES(10), .VALID_LEN(8)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .abort(abort),
        .ready(ready3), .busy(busy3), .sb(sb3), .isl(isl3), .stage_first(first3),
        .stage_last(last3), .frame_done(fd3), .valid(valid3), .fsm_state(st3));

    assign obs[0] = {st0, 4'(sb0), busy0, isl0, first0, last0, fd0, valid0, ready0};
    assign obs[1] = {st1, 4'(sb1), busy1, isl1, first1, last1, fd1, valid1, ready1};
    assign obs[2] = {st2, 4'(sb2), busy2, isl2, first2, last2, fd2, valid2, ready2};
    assign obs[3] = {st3, 4'(sb3), busy3, isl3, first3, last3, fd3, valid3, ready3};

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %b expected %b (state,sb,busy,isl,first,last,done,valid,ready)",
                     tag, cyc, got, exp);
        end
    endtask

    function automatic logic [11:0] expect_vec(input int i);
        logic rdy;
        logic vld;
        rdy = !abort && (!m_busy[i] || ((m_stage[i] == NS[i]) && !stall));
        vld = (cyc <= m_vend[i]);
        return {m_busy[i], 4'(m_stage[i]), m_busy[i], m_busy[i],
                m_busy[i] && (m_stage[i] == 1), m_busy[i] && (m_stage[i] == NS[i]),
                m_fd[i], vld, rdy};
    endfunction

    task automatic check_all(input string what);
        for (int i = 0; i < NI; i++)
            check($sformatf("%s_n%0d_v%0d", what, NS[i], VL[i]), obs[i], expect_vec(i));
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_busy[i]  = 1'b0;
            m_stage[i] = 0;
            m_fd[i]    = 1'b0;
            m_vend[i]  = -1;
        end
    endtask

    task automatic model_step();
        cyc++;
        for (int i = 0; i < NI; i++) begin
            m_fd[i] = 1'b0;
            if (abort) begin
                m_busy[i]  = 1'b0;
                m_stage[i] = 0;
                m_vend[i]  = -1;
            end else if (!m_busy[i]) begin
                if (start) begin
                    m_busy[i]  = 1'b1;
                    m_stage[i] = 1;
                end
            end else if (!stall) begin
                if (m_stage[i] < NS[i]) begin
                    m_stage[i]++;
                end else begin
                    m_fd[i]   = 1'b1;
                    m_vend[i] = cyc + VL[i] - 1;
                    if (start) begin
                        m_stage[i] = 1;
                    end else begin
                        m_busy[i]  = 1'b0;
                        m_stage[i] = 0;
                    end
                end
            end
        end
    endtask

    // driver: one clock cycle with the given inputs
    task automatic step(input logic s, input logic st, input logic ab);
        start = s;
        stall = st;
        abort = ab;
        @(negedge clk);
        check_all("cyc");
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic reset_pulse();
        start = 1'b0;
        stall = 1'b0;
        abort = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        stall = 1'b0;
        abort = 1'b0;
        model_reset();
        #2;
        check_all("reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        // single frame
        step(1'b1, 1'b0, 1'b0);
        idle(14);

        // back-to-back: start held for three frames
        for (int k = 0; k < 15; k++) step(1'b1, 1'b0, 1'b0);
        idle(12);

        // stall two cycles at sb=3, then one cycle at sb=5
        step(1'b1, 1'b0, 1'b0);
        idle(2);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        idle(2);
        step(1'b0, 1'b1, 1'b0);
        idle(14);

        // abort at sb=2
        step(1'b1, 1'b0, 1'b0);
        idle(1);
        step(1'b0, 1'b0, 1'b1);
        idle(14);

        // abort inside the valid window, with start high at the same time
        step(1'b1, 1'b0, 1'b0);
        idle(7);
        step(1'b1, 1'b0, 1'b1);
        idle(14);

        // asynchronous reset at sb=4, then a fresh frame
        step(1'b1, 1'b0, 1'b0);
        idle(3);
        reset_pulse();
        step(1'b1, 1'b0, 1'b0);
        idle(14);

        // randomized traffic
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 299) == 0) begin
                reset_pulse();
            end else begin
                step(logic'($urandom_range(0, 99) < 55),
                     logic'($urandom_range(0, 99) < 20),
                     logic'($urandom_range(0, 99) < 3));
            end
        end
        idle(14);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
